// File: rtl/rx_sched_pkg.sv
// Shared constants for the LCD receive byte scheduler: button codes, pacing FSM states, defaults.
// Button vectors are ordered {C, N, E, S, W}, so bit 4 is the highest priority.
package rx_sched_pkg;

    localparam logic [7:0] CODE_C = 8'h43;
    localparam logic [7:0] CODE_N = 8'h4E;
    localparam logic [7:0] CODE_E = 8'h45;
    localparam logic [7:0] CODE_S = 8'h53;
    localparam logic [7:0] CODE_W = 8'h57;

    localparam int HOLD_DEF = 8;
    localparam int GAP_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // One-hot of the highest set bit; the later (higher) index overwrites earlier hits.
    function automatic logic [4:0] pick_hi(input logic [4:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (v[i]) r = 5'(1) << i;
        end
        return r;
    endfunction

    function automatic logic [7:0] btn_code(input logic [4:0] onehot);
        logic [7:0] c;
        c = 8'h00;
        if      (onehot[4]) c = CODE_C;
        else if (onehot[3]) c = CODE_N;
        else if (onehot[2]) c = CODE_E;
        else if (onehot[1]) c = CODE_S;
        else if (onehot[0]) c = CODE_W;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2^AW entries; push into a full FIFO is discarded, pop of an empty one ignored.
// Head data is combinational from the read pointer; level updates on the same edge as push/pop.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          CLK50M,
    input  logic          nRST,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_en, rd_en;

    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign wr_en      = push_i & ~full_o;
    assign rd_en      = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !rd_en) level_d = level_q + 1'b1;
        if (!wr_en && rd_en) level_d = level_q - 1'b1;
    end

    always_ff @(posedge CLK50M or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge CLK50M) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/rx_byte_sched.sv
// Merges receiver bytes and debounced button codes into one FIFO and paces them out as valid_o pulses.
// Receiver byte reaches valid_o two edges after its strobe when idle; no backpressure, full FIFO drops rx bytes.
module rx_byte_sched
    import rx_sched_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int HOLD_CYCLES    = HOLD_DEF,
    parameter int GAP_CYCLES     = GAP_DEF,
    parameter int LOCKOUT_CYCLES = 1_000_000
) (
    input  logic               CLK50M,
    input  logic               nRST,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               BTN_N,
    input  logic               BTN_E,
    input  logic               BTN_S,
    input  logic               BTN_W,
    input  logic               BTN_C,
    input  logic               clr_ovf,
    output logic               valid_o,
    output logic [7:0]         data_o,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);

    logic [4:0]      btn_s1_q, btn_s2_q, btn_s3_q;
    logic [4:0]      btn_edge, btn_accept, btn_grant;
    logic [4:0]      pend_q, pend_d;
    logic [LK_W-1:0] lk_q, lk_d;
    logic            btn_ok, push, pop, drop;
    logic [7:0]      push_dat, head_dat;
    logic            fifo_full, fifo_empty;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;
    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;

    assign btn_edge   = btn_s2_q & ~btn_s3_q;
    assign btn_accept = (lk_q == '0) ? pick_hi(btn_edge) : 5'b0;

    // Buttons never take the last free entry, so a receiver byte always has room after one.
    assign btn_ok    = !rx_valid && (pend_q != '0) && (fifo_level <= (FIFO_AW+1)'(DEPTH - 2));
    assign btn_grant = btn_ok ? pick_hi(pend_q) : 5'b0;
    assign push      = rx_valid | btn_ok;
    assign push_dat  = rx_valid ? rx_data : btn_code(btn_grant);
    assign drop      = rx_valid & fifo_full;

    always_comb begin
        pend_d = (pend_q & ~btn_grant) | btn_accept;
        lk_d   = lk_q;
        if (btn_accept != '0)  lk_d = LK_W'(LOCKOUT_CYCLES);
        else if (lk_q != '0)   lk_d = lk_q - 1'b1;

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .CLK50M     (CLK50M),
        .nRST       (nRST),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                data_d  = head_dat;
                valid_d = 1'b1;
                cnt_d   = 8'(HOLD_CYCLES - 1);
                state_d = ST_HOLD;
            end
            ST_HOLD: if (cnt_q == '0) begin
                valid_d = 1'b0;
                cnt_d   = 8'(GAP_CYCLES - 1);
                state_d = ST_GAP;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            ST_GAP: if (cnt_q == '0) state_d = ST_IDLE;
                    else cnt_d = cnt_q - 8'd1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50M or negedge nRST) begin
        if (!nRST) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_s3_q <= '0;
            pend_q   <= '0;
            lk_q     <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            btn_s1_q <= {BTN_C, BTN_N, BTN_E, BTN_S, BTN_W};
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            pend_q   <= pend_d;
            lk_q     <= lk_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rx_byte_sched.sv
// Directed bench for rx_byte_sched: timing, overflow, button lockout/priority, reserved slot, async reset.
module tb_rx_byte_sched;
    localparam int HOLD = 8;

    logic       CLK50M = 1'b0;
    logic       nRST;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       BTN_N, BTN_E, BTN_S, BTN_W, BTN_C;
    logic       clr_ovf;
    logic       valid_o;
    logic [7:0] data_o;
    logic [3:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int base, base2;

    logic [7:0] got_q[$];
    int         rise_q[$];
    logic       mon_en;
    logic       mon_prev = 1'b0;
    int         mon_hold = 0;
    logic [7:0] mon_dat  = 8'h00;
    logic       mon_stable = 1'b1;

    rx_byte_sched #(
        .FIFO_AW(3), .HOLD_CYCLES(8), .GAP_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .CLK50M(CLK50M), .nRST(nRST), .rx_valid(rx_valid), .rx_data(rx_data),
        .BTN_N(BTN_N), .BTN_E(BTN_E), .BTN_S(BTN_S), .BTN_W(BTN_W), .BTN_C(BTN_C),
        .clr_ovf(clr_ovf), .valid_o(valid_o), .data_o(data_o),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #10 CLK50M = ~CLK50M;
    always @(posedge CLK50M) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK50M);
        #1;
    endtask

    function automatic logic [8:0] got_at(input int idx);
        if (idx < got_q.size()) return {1'b0, got_q[idx]};
        return 9'h1FF;
    endfunction

    // Records every rising edge of valid_o and checks each pulse's width and data stability.
    always @(negedge CLK50M) begin
        if (!nRST) begin
            mon_prev = 1'b0;
            mon_hold = 0;
        end else begin
            if (valid_o && !mon_prev) begin
                got_q.push_back(data_o);
                rise_q.push_back(cyc);
                mon_hold   = 1;
                mon_dat    = data_o;
                mon_stable = 1'b1;
            end else if (valid_o) begin
                mon_hold++;
                if (data_o !== mon_dat) mon_stable = 1'b0;
            end else if (mon_prev && mon_en) begin
                chk("hold_len", mon_hold, HOLD);
                chk("hold_data_stable", {31'b0, mon_stable}, 1);
            end
            mon_prev = valid_o;
        end
    end

    initial begin
        nRST = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; clr_ovf = 1'b0; mon_en = 1'b1;
        BTN_N = 0; BTN_E = 0; BTN_S = 0; BTN_W = 0; BTN_C = 0;
        repeat (3) tick();
        chk("rst_valid_in", valid_o, 0);
        nRST = 1'b1;
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single byte: written at edge k, valid high after edges k+1..k+8.
        rx_data = 8'h31; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("sb_valid_k", valid_o, 0);
        chk("sb_level_k", fifo_level, 1);
        tick();
        chk("sb_valid_k1", valid_o, 1);
        chk("sb_data_k1", data_o, 8'h31);
        chk("sb_level_k1", fifo_level, 0);
        repeat (7) tick();
        chk("sb_valid_k8", valid_o, 1);
        tick();
        chk("sb_valid_k9", valid_o, 0);
        chk("sb_data_k9", data_o, 8'h31);
        repeat (20) tick();

        // Burst of 10: first popped at once, next 8 fill the FIFO, 0x0A dropped.
        base = got_q.size();
        for (int j = 0; j < 10; j++) begin
            rx_data = 8'(j + 1); rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        chk("burst_level", fifo_level, 8);
        chk("burst_ovf", overflow, 1);
        chk("burst_drop", drop_cnt, 1);
        repeat (170) tick();
        chk("burst_count", got_q.size() - base, 9);
        for (int i = 0; i < 9; i++) chk("burst_byte", got_at(base + i), 9'(i + 1));
        chk("burst_period", rise_q[base + 1] - rise_q[base], 17);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);

        // BTN_C with bounce inside the lockout window: one byte.
        base = got_q.size();
        BTN_C = 1; repeat (3) tick();
        BTN_C = 0; repeat (2) tick();
        BTN_C = 1; repeat (2) tick();
        BTN_C = 0; repeat (40) tick();
        chk("btnc_count", got_q.size() - base, 1);
        chk("btnc_byte", got_at(base), 9'h043);

        // W and C edges together: only the C code survives.
        base = got_q.size();
        BTN_W = 1; BTN_C = 1; repeat (3) tick();
        BTN_W = 0; BTN_C = 0; repeat (40) tick();
        chk("simul_count", got_q.size() - base, 1);
        chk("simul_byte", got_at(base), 9'h043);

        // 40 cycles of rx keep the FIFO saturated; W then C become pending; clr collides with a drop.
        base = got_q.size();
        for (int j = 0; j < 40; j++) begin
            rx_data = 8'(8'h80 + j); rx_valid = 1'b1;
            if (j == 1)  BTN_W = 1;
            if (j == 25) BTN_C = 1;
            clr_ovf = (j == 37);
            tick();
            if (j == 36) chk("prio_drop_36", drop_cnt, 26);
        end
        rx_valid = 1'b0; clr_ovf = 1'b0; BTN_W = 0; BTN_C = 0;
        chk("prio_level", fifo_level, 8);
        chk("prio_ovf", overflow, 1);
        chk("prio_drop_end", drop_cnt, 3);
        repeat (200) tick();
        chk("prio_count", got_q.size() - base, 13);
        for (int i = 0; i < 9; i++) chk("prio_rx_byte", got_at(base + i), 9'(8'h80 + i));
        chk("prio_rx_93", got_at(base + 9), 9'h093);
        chk("prio_rx_a4", got_at(base + 10), 9'h0A4);
        chk("prio_first_c", got_at(base + 11), 9'h043);
        chk("prio_then_w", got_at(base + 12), 9'h057);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

        // Reserved slot: N pending while level 7, rx 0x55 still accepted, N waits for two frees.
        base = got_q.size();
        for (int j = 0; j < 9; j++) begin
            rx_data = (j < 8) ? 8'(8'h11 + j) : 8'h55; rx_valid = 1'b1;
            if (j == 0) BTN_N = 1;
            tick();
        end
        rx_valid = 1'b0;
        chk("resv_level_full", fifo_level, 8);
        chk("resv_no_ovf", overflow, 0);
        repeat (11) tick();
        chk("resv_level_one_free", fifo_level, 7);
        BTN_N = 0;
        repeat (190) tick();
        chk("resv_count", got_q.size() - base, 10);
        for (int i = 0; i < 8; i++) chk("resv_rx_byte", got_at(base + i), 9'(8'h11 + i));
        chk("resv_byte_55", got_at(base + 8), 9'h055);
        chk("resv_byte_n", got_at(base + 9), 9'h04E);
        chk("resv_drop", drop_cnt, 0);

        // Asynchronous reset during HOLD with bytes still queued.
        base = got_q.size();
        for (int j = 0; j < 3; j++) begin
            rx_data = 8'(8'hA1 + j); rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        repeat (3) tick();
        chk("rstmid_in_hold", valid_o, 1);
        mon_en = 1'b0;
        @(posedge CLK50M);
        #5;
        nRST = 1'b0;
        #1;
        chk("rstmid_valid", valid_o, 0);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_data", data_o, 8'h00);
        tick(); tick();
        nRST = 1'b1;
        base2 = got_q.size();
        chk("rstmid_inflight", base2 - base, 1);
        mon_en = 1'b1;
        repeat (60) tick();
        chk("rstmid_no_stale", got_q.size() - base2, 0);
        chk("rstmid_level_after", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
